// File: rtl/mem_arbiter_filter.sv
// Two-requester round-robin memory arbiter with an address-window access filter.
// One access is in flight at a time: the winner's request is latched at grant,
// checked against the sampled filter configuration, and either issued to memory
// (ACCESS, then WAIT for reads) or rejected with an error pulse (ERR).
module mem_arbiter_filter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  m0_req,
    input  logic                  m0_wr,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_wr,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    input  logic [1:0]            ctrl_reg,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] end_addr,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP,
        ERR
    } state_t;

    // WAIT runs RD_LATENCY cycles; the counter value of the final one.
    localparam logic [2:0] LAST_CNT = 3'(RD_LATENCY - 1);

    state_t                  state;
    state_t                  state_nxt;
    logic                    last_grant;   // 0 = m0, 1 = m1
    logic                    cur_idx;
    logic                    cur_wr;
    logic [2:0]              wait_cnt;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    any_req;
    logic                    grant_idx;
    logic                    sel_wr;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    in_window;
    logic                    permitted;
    logic                    wait_done;
    logic                    ack_any;
    logic [DATA_WIDTH-1:0]   resp_rdata;

    assign any_req   = m0_req | m1_req;
    assign wait_done = (wait_cnt == LAST_CNT);

    // Round-robin pick: on a tie the requester not granted last wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
        grant_idx = 1'b0;
        if (m0_req && m1_req) begin
            grant_idx = ~last_grant;
        end else if (m1_req) begin
            grant_idx = 1'b1;
        end
    end

    assign sel_wr    = grant_idx ? m1_wr    : m0_wr;
    assign sel_addr  = grant_idx ? m1_addr  : m0_addr;
    assign sel_wdata = grant_idx ? m1_wdata : m0_wdata;

    // Unsigned inclusive window; start above end naturally yields an empty window.
    assign in_window = (sel_addr >= start_addr) && (sel_addr <= end_addr);
    assign permitted = !ctrl_reg[0] || (ctrl_reg[1] ? in_window : !in_window);

    // State register.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = permitted ? ACCESS : ERR;
            ACCESS:  state_nxt = cur_wr ? RESP : WAIT;
            WAIT:    if (wait_done) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant latching, memory-side registers, read-latency counter and data capture.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            last_grant <= 1'b1;
            cur_idx    <= 1'b0;
            cur_wr     <= 1'b0;
            wait_cnt   <= '0;
            rdata_q    <= '0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        cur_idx    <= grant_idx;
                        cur_wr     <= sel_wr;
                        last_grant <= grant_idx;
                        // Memory-side fields only move for accesses that are issued,
                        // so they hold their last values across filtered requests.
                        if (permitted) begin
                            mem_wr    <= sel_wr;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                        end
                    end
                end
                WAIT: begin
                    if (wait_done) begin
                        rdata_q  <= mem_rdata;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Response and memory strobes decoded from the current state.
    assign ack_any    = (state == RESP) || (state == ERR);
    assign resp_rdata = ((state == RESP) && !cur_wr) ? rdata_q : '0;

    assign m0_ack   = ack_any && !cur_idx;
    assign m1_ack   = ack_any &&  cur_idx;
    assign m0_err   = (state == ERR) && !cur_idx;
    assign m1_err   = (state == ERR) &&  cur_idx;
    assign m0_rdata = cur_idx ? '0 : resp_rdata;
    assign m1_rdata = cur_idx ? resp_rdata : '0;
    assign mem_en   = (state == ACCESS);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter_filter.sv
// Directed bench for mem_arbiter_filter: a behavioural memory with fixed read
// latency, a response scoreboard and latency checks measured from the grant edge.
module tb_mem_arbiter_filter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RL = 2;

    logic          hclk = 1'b0;
    logic          hreset;
    logic          m0_req, m0_wr, m1_req, m1_wr;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [1:0]    ctrl_reg;
    logic [AW-1:0] start_addr, end_addr;
    logic          mem_en, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    mem_arbiter_filter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RL)) dut (
        .hclk(hclk), .hreset(hreset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .ctrl_reg(ctrl_reg), .start_addr(start_addr), .end_addr(end_addr),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 hclk = ~hclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural memory: reads return data RL cycles after the strobe cycle.
    logic [DW-1:0] mem [logic [AW-1:0]];
    logic [DW-1:0] pipe [0:RL];
    int            en_count = 0;
    logic          last_wr;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;

    initial begin
        for (int i = 0; i <= RL; i++) pipe[i] = 32'hDEAD_BEEF;
        mem_rdata = 32'hDEAD_BEEF;
    end

    always @(negedge hclk) begin
        if (mem_en === 1'b1) begin
            en_count++;
            last_wr    = mem_wr;
            last_addr  = mem_addr;
            last_wdata = mem_wdata;
            if (mem_wr) mem[mem_addr] = mem_wdata;
        end
        for (int i = RL; i > 0; i--) pipe[i] = pipe[i-1];
        if (mem_en === 1'b1 && mem_wr === 1'b0)
            pipe[0] = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0BAD_0BAD;
        else
            pipe[0] = 32'hDEAD_BEEF;
        mem_rdata = pipe[RL];
    end

    // Scoreboard of expected responses, popped whenever an ack appears.
    typedef struct {
        logic          idx;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];

    always @(negedge hclk) begin
        exp_t e;
        if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
            check("single_ack", 32'(m0_ack & m1_ack), 32'd0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL unexpected_ack: observed m0_ack=%0b m1_ack=%0b expected no ack", m0_ack, m1_ack);
            end else begin
                e = sb.pop_front();
                check("ack_idx", 32'(m1_ack), 32'(e.idx));
                check("ack_err", 32'(m1_ack ? m1_err : m0_err), 32'(e.err));
                check("ack_rdata", m1_ack ? m1_rdata : m0_rdata, e.rdata);
                check("idle_side_quiet", 32'(m1_ack ? m0_err : m1_err) | (m1_ack ? m0_rdata : m1_rdata), 32'd0);
            end
        end
    end

    // One access from requester idx; latency counted in cycles from the grant edge.
    task automatic do_access(input logic idx, input logic wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input int exp_lat, input logic exp_err,
                             input logic [DW-1:0] exp_rdata, input int flip_ctrl, input string tag);
        exp_t e;
        int   en0;
        int   lat;
        e.idx = idx; e.err = exp_err; e.rdata = exp_rdata;
        sb.push_back(e);
        en0 = en_count;
        if (idx) begin
            m1_req = 1'b1; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
        end
        @(posedge hclk);
        if (flip_ctrl >= 0) begin
            #1;
            ctrl_reg = 2'(flip_ctrl);
        end
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge hclk);
            if ((idx ? m1_ack : m0_ack) === 1'b1) begin
                lat = k;
                break;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check({tag, "_latency"}, lat, exp_lat);
        @(negedge hclk);
        check({tag, "_mem_en_cycles"}, en_count - en0, exp_err ? 0 : 1);
    endtask

    task automatic apply_reset();
        hreset = 1'b1;
        repeat (2) @(negedge hclk);
        hreset = 1'b0;
        @(negedge hclk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        hreset = 1'b1;
        m0_req = 1'b0; m0_wr = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_wr = 1'b0; m1_addr = '0; m1_wdata = '0;
        ctrl_reg = 2'b00; start_addr = '0; end_addr = '0;
        mem[32'h20]  = 32'h0000_1234;
        mem[32'h150] = 32'h5555_AAAA;
        mem[32'h1FF] = 32'h0000_01FF;
        mem[32'h200] = 32'h0000_0200;

        // Reset state.
        repeat (3) @(negedge hclk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_acks", 32'(m0_ack | m1_ack | m0_err | m1_err), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        hreset = 1'b0;
        @(negedge hclk);

        // Unfiltered write, read-back and plain read.
        do_access(1'b0, 1'b1, 32'h10, 32'hA5A5, 2, 1'b0, 32'h0, -1, "wr_m0");
        check("wr_mem_addr", last_addr, 32'h10);
        check("wr_mem_wr", 32'(last_wr), 32'd1);
        check("wr_mem_wdata", last_wdata, 32'hA5A5);
        check("hold_mem_addr", mem_addr, 32'h10);
        check("hold_mem_en", 32'(mem_en), 32'd0);
        do_access(1'b1, 1'b0, 32'h10, 32'h0, 4, 1'b0, 32'hA5A5, -1, "rd_back");
        do_access(1'b1, 1'b0, 32'h20, 32'h0, 4, 1'b0, 32'h1234, -1, "rd_m1");
        check("rd_mem_addr", last_addr, 32'h20);

        // Block-window mode.
        ctrl_reg = 2'b01; start_addr = 32'h100; end_addr = 32'h1FF;
        do_access(1'b0, 1'b0, 32'h100, 32'h0, 1, 1'b1, 32'h0, -1, "blk_lo_edge");
        do_access(1'b0, 1'b0, 32'h200, 32'h0, 4, 1'b0, 32'h200, -1, "blk_outside");
        do_access(1'b0, 1'b1, 32'h1FF, 32'h77, 1, 1'b1, 32'h0, -1, "blk_wr_hi_edge");
        check("blk_hold_mem_addr", mem_addr, 32'h200);

        // Permit-window mode, including an empty window.
        ctrl_reg = 2'b11;
        do_access(1'b1, 1'b0, 32'h1FF, 32'h0, 4, 1'b0, 32'h1FF, -1, "win_hi_edge");
        do_access(1'b1, 1'b0, 32'h0FF, 32'h0, 1, 1'b1, 32'h0, -1, "win_below");
        do_access(1'b1, 1'b0, 32'h150, 32'h0, 4, 1'b0, 32'h5555_AAAA, -1, "win_mid");
        start_addr = 32'h300; end_addr = 32'h200;
        do_access(1'b0, 1'b0, 32'h250, 32'h0, 1, 1'b1, 32'h0, -1, "empty_mid");
        do_access(1'b0, 1'b0, 32'h300, 32'h0, 1, 1'b1, 32'h0, -1, "empty_start");

        // Configuration changed right after grant leaves the access untouched.
        ctrl_reg = 2'b00; start_addr = 32'h100; end_addr = 32'h1FF;
        do_access(1'b1, 1'b0, 32'h150, 32'h0, 4, 1'b0, 32'h5555_AAAA, 1, "cfg_flip_ok");
        do_access(1'b0, 1'b0, 32'h150, 32'h0, 1, 1'b1, 32'h0, 0, "cfg_flip_err");
        ctrl_reg = 2'b10;
        do_access(1'b0, 1'b0, 32'h150, 32'h0, 4, 1'b0, 32'h5555_AAAA, -1, "mode10_all");

        // Both requesters continuously from reset: m0, m1, m0, m1.
        ctrl_reg = 2'b00;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.idx = 1'(i % 2); e.err = 1'b0; e.rdata = '0;
            sb.push_back(e);
        end
        m0_wr = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h11;
        m1_wr = 1'b1; m1_addr = 32'h44; m1_wdata = 32'h22;
        m0_req = 1'b1; m1_req = 1'b1;
        got = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge hclk);
            if (m0_ack === 1'b1 || m1_ack === 1'b1) got++;
            if (got >= 4) break;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        check("rr_ack_count", got, 4);
        @(negedge hclk);
        check("rr_idle_busy", 32'(busy), 32'd0);

        // Reset during WAIT abandons the read.
        m0_wr = 1'b0; m0_addr = 32'h20; m0_req = 1'b1;
        @(posedge hclk);
        @(posedge hclk);
        @(negedge hclk);
        check("mid_busy", 32'(busy), 32'd1);
        #1 hreset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_strobes", 32'(mem_en | mem_wr | m0_ack | m1_ack | m0_err | m1_err), 32'd0);
        check("mid_rst_mem_addr", mem_addr, 32'd0);
        check("mid_rst_mem_wdata", mem_wdata, 32'd0);
        check("mid_rst_rdata", m0_rdata | m1_rdata, 32'd0);
        m0_req = 1'b0;
        repeat (2) @(negedge hclk);
        hreset = 1'b0;
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge hclk);
            if (m0_ack === 1'b1 || m1_ack === 1'b1) got++;
        end
        check("post_rst_no_ack", got, 0);
        do_access(1'b1, 1'b1, 32'h60, 32'h99, 2, 1'b0, 32'h0, -1, "post_rst_wr");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
